// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// Computes {Cout, Sum} = A + B + Cin using a single full adder, one bit per
// clock, LSB first. Operands are captured on the Start edge, so later input
// changes do not disturb an operation in flight.
//
// Ports:
//   CLK   - clock, rising edge
//   RST   - synchronous active-high reset; clears all state and outputs
//   Start - request an addition; honoured only in IDLE
//   A, B  - WIDTH-bit unsigned operands
//   Cin   - carry into bit 0
//   Busy  - high in RUN and DONE
//   Done  - one-cycle pulse in DONE, result valid
//   Sum   - registered result, updated only on completion
//   Cout  - registered carry out of bit WIDTH-1, updated only on completion

module FullAdder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);
    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic fa_a, fa_b, fa_sum, fa_cout;

    assign fa_a = a_q[idx_q];
    assign fa_b = b_q[idx_q];

    FullAdder u_fa (
        .A    (fa_a),
        .B    (fa_b),
        .Cin  (carry_q),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d  = RUN;
                    a_d      = A;
                    b_d      = B;
                    carry_d  = Cin;
                    idx_d    = '0;
                    result_d = '0;
                end
            end
            RUN: begin
                result_d[idx_q] = fa_sum;
                carry_d         = fa_cout;
                idx_d           = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    // Last bit: publish the complete result including this bit.
                    state_d = DONE;
                    sum_d   = result_d;
                    cout_d  = fa_cout;
                    idx_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign Busy = (state_q == RUN) || (state_q == DONE);
    assign Done = (state_q == DONE);
    assign Sum  = sum_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed self-checking bench for serial_add_ctrl (WIDTH=8).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_serial_add_ctrl;
    localparam int unsigned WIDTH = 8;

    logic             CLK;
    logic             RST;
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;

    int n_cmp;
    int n_err;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Busy  (Busy),
        .Done  (Done),
        .Sum   (Sum),
        .Cout  (Cout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic test_reset();
        RST = 1'b1; Start = 1'b0; A = 8'h5A; B = 8'hA5; Cin = 1'b1;
        repeat (3) @(negedge CLK);
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", Busy); end
        n_cmp++; if (Done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", Done); end
        n_cmp++; if (Sum !== 8'h00) begin n_err++; $display("FAIL reset_sum got=%h want=00", Sum); end
        n_cmp++; if (Cout !== 1'b0) begin n_err++; $display("FAIL reset_cout got=%b want=0", Cout); end
        // Start while in reset must be ignored.
        Start = 1'b1;
        @(negedge CLK);
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_prio_busy got=%b want=0", Busy); end
        Start = 1'b0;
        RST = 1'b0;
        @(negedge CLK);
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got=%b want=0", Busy); end
    endtask

    // One operation from IDLE; inputs are scrambled right after the Start edge.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin);
        logic [8:0] want;
        logic [7:0] prev_sum;
        logic       prev_cout;
        want = {1'b0, a} + {1'b0, b} + {8'h00, cin};
        @(negedge CLK);
        prev_sum  = Sum;
        prev_cout = Cout;
        Start = 1'b1; A = a; B = b; Cin = cin;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                Start = 1'b0; A = ~a; B = b ^ 8'h5A; Cin = ~cin;
            end
            n_cmp++;
            if (Busy !== (k <= 9)) begin
                n_err++;
                $display("FAIL op_busy a=%h b=%h cin=%b cyc=%0d got=%b want=%b", a, b, cin, k, Busy, k <= 9);
            end
            n_cmp++;
            if (Done !== (k == 9)) begin
                n_err++;
                $display("FAIL op_done a=%h b=%h cin=%b cyc=%0d got=%b want=%b", a, b, cin, k, Done, k == 9);
            end
            if (k < 9) begin
                n_cmp++;
                if ({Cout, Sum} !== {prev_cout, prev_sum}) begin
                    n_err++;
                    $display("FAIL op_hold a=%h b=%h cyc=%0d got=%b_%h want=%b_%h", a, b, k, Cout, Sum, prev_cout, prev_sum);
                end
            end else begin
                n_cmp++;
                if ({Cout, Sum} !== want) begin
                    n_err++;
                    $display("FAIL op_result a=%h b=%h cin=%b cyc=%0d got=%b_%h want=%b_%h", a, b, cin, k, Cout, Sum, want[8], want[7:0]);
                end
            end
        end
        A = '0; B = '0; Cin = 1'b0;
    endtask

    task automatic test_vectors();
        run_op(8'h00, 8'h00, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'hA5, 8'h5A, 1'b1);
        run_op(8'h3C, 8'h41, 1'b0);
        run_op(8'hFF, 8'h00, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b1);
        run_op(8'h12, 8'h34, 1'b1);
    endtask

    task automatic test_start_ignored();
        int done_cnt;
        int done_cyc;
        done_cnt = 0;
        done_cyc = -1;
        @(negedge CLK);
        Start = 1'b1; A = 8'h12; B = 8'h34; Cin = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            Start = (k == 3) || (k == 9);
            if (k == 3) begin A = 8'hFF; B = 8'hFF; Cin = 1'b1; end
            if (k == 5) begin A = 8'h80; B = 8'h80; end
            if (Done === 1'b1) begin
                done_cnt++;
                done_cyc = k;
                n_cmp++;
                if ({Cout, Sum} !== 9'h046) begin
                    n_err++;
                    $display("FAIL ign_result got=%b_%h want=0_46", Cout, Sum);
                end
            end
        end
        Start = 1'b0;
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL ign_done_count got=%0d want=1", done_cnt); end
        n_cmp++; if (done_cyc !== 9) begin n_err++; $display("FAIL ign_done_cycle got=%0d want=9", done_cyc); end
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL ign_busy_after got=%b want=0", Busy); end
    endtask

    task automatic test_back_to_back();
        @(negedge CLK);
        Start = 1'b1; A = 8'h01; B = 8'h01; Cin = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge CLK);
            n_cmp++;
            if (Busy !== ((k % 10) != 0)) begin
                n_err++;
                $display("FAIL b2b_busy cyc=%0d got=%b want=%b", k, Busy, (k % 10) != 0);
            end
            n_cmp++;
            if (Done !== ((k % 10) == 9)) begin
                n_err++;
                $display("FAIL b2b_done cyc=%0d got=%b want=%b", k, Done, (k % 10) == 9);
            end
            if ((k % 10) == 9) begin
                n_cmp++;
                if ({Cout, Sum} !== 9'h002) begin
                    n_err++;
                    $display("FAIL b2b_result cyc=%0d got=%b_%h want=0_02", k, Cout, Sum);
                end
            end
        end
        Start = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset_abort();
        int done_cnt;
        // Leave a nonzero Sum and Cout behind so the clear is visible.
        run_op(8'h80, 8'h81, 1'b0);
        @(negedge CLK);
        Start = 1'b1; A = 8'h7F; B = 8'h7F; Cin = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            Start = 1'b0;
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b want=0", Busy); end
        n_cmp++; if (Sum !== 8'h00) begin n_err++; $display("FAIL abort_sum got=%h want=00", Sum); end
        n_cmp++; if (Cout !== 1'b0) begin n_err++; $display("FAIL abort_cout got=%b want=0", Cout); end
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            if (Done === 1'b1) done_cnt++;
        end
        n_cmp++; if (done_cnt !== 0) begin n_err++; $display("FAIL abort_no_done got=%0d want=0", done_cnt); end
        n_cmp++; if ({Cout, Sum} !== 9'h000) begin n_err++; $display("FAIL abort_hold got=%b_%h want=0_00", Cout, Sum); end
        run_op(8'h3C, 8'h41, 1'b0);
    endtask

    task automatic test_sweep();
        logic [7:0] vals [8];
        vals = '{8'h00, 8'h01, 8'h0F, 8'h55, 8'h7F, 8'h80, 8'hAA, 8'hFF};
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                run_op(vals[i], vals[j], 1'b0);
                run_op(vals[i], vals[j], 1'b1);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        RST = 1'b1; Start = 1'b0; A = '0; B = '0; Cin = 1'b0;
        test_reset();
        test_vectors();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
